serial_add_seq: RTL and testbench

- Bit-serial adder sequencer. Reuses a single gate-level 1-bit full-adder cell (sum path 40 time units, carry path 60 time units) to add two WIDTH-bit operands, LSB first, one bit per clock.
- Holds the carry in a flop between bits and assembles the result in a shift register.
- Provides a start/busy/done handshake so an upstream controller can share one small adder for wide additions.

---
 rtl/serial_add_seq.sv | 172 +++++++++++++++++
 tb/tb_serial_add_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq -- bit-serial adder sequencer.
//
// Adds two WIDTH-bit operands LSB first, one bit per clock, through a single
// 1-bit full-adder cell. The carry lives in a flop between bits and the result
// is assembled in a right-shifting register, then copied to sum on completion.
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   : sub=1 at accept loads ~b and forces carry-in to 1 (a - b).
//   undefined : sub is ignored; the block always computes a + b + cIn.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; accepted in IDLE or DONE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   cIn    in   carry-in, sampled on the accepting edge
//   sub    in   subtract select (SERIAL_SUB_EN builds only)
//   busy   out  high while bits are being processed
//   done   out  one-cycle completion strobe
//   sum    out  registered result, held until the next completion
//   cOut   out  final carry-out, registered with sum
//   ovf    out  signed overflow, registered with sum

// Gate-level 1-bit full adder shared by every bit position.
module FullAdderCell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic halfSum;

  assign halfSum = a ^ b;
  assign s       = halfSum ^ ci;
  assign co      = (a & b) | (ci & halfSum);
endmodule

module serial_add_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  stateT            nextState;
  logic             accept;
  logic             lastBit;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-2:0] shReg;
  logic [WIDTH-1:0] sumNext;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             faSum;
  logic             faCarry;
  logic [WIDTH-1:0] loadB;
  logic             loadCarry;

  // Values loaded on accept; subtraction is a + ~b + 1 through the same cell.
`ifdef SERIAL_SUB_EN
  assign loadB     = sub ? ~b : b;
  assign loadCarry = sub ? 1'b1 : cIn;
`else
  logic unusedSub;
  assign unusedSub = sub;
  assign loadB     = b;
  assign loadCarry = cIn;
`endif

  FullAdderCell fullAdder (
    .a  (opA[0]),
    .b  (opB[0]),
    .ci (carry),
    .s  (faSum),
    .co (faCarry)
  );

  assign lastBit = (cnt == CNT_W'(WIDTH - 1));

  // The result register only keeps WIDTH-1 bits; the final bit comes straight
  // from the adder on the completion edge.
  assign sumNext = {faSum, shReg};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs; start is only honoured in IDLE or DONE,
  // which gives back-to-back operation with no idle gap.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (lastBit) begin
          nextState = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          nextState = RUN;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, publish results
  // only on the last bit so sum/cOut/ovf stay stable during a later run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA   <= '0;
      opB   <= '0;
      shReg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cOut  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      opA   <= a;
      opB   <= loadB;
      carry <= loadCarry;
      cnt   <= '0;
    end else if (state == RUN) begin
      opA   <= opA >> 1;
      opB   <= opB >> 1;
      shReg <= sumNext[WIDTH-1:1];
      carry <= faCarry;
      cnt   <= cnt + CNT_W'(1);
      if (lastBit) begin
        sum  <= sumNext;
        cOut <= faCarry;
        // carry still holds the carry into the MSB at this point
        ovf  <= carry ^ faCarry;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq -- self-checking bench for serial_add_seq at WIDTH=8.
// Directed cases plus randomized operations checked against an arithmetic
// reference model. Builds with or without SERIAL_SUB_EN.
module tb_serial_add_seq;
  localparam int WIDTH = 8;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cOut;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cIn   (cIn),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cOut  (cOut),
    .ovf   (ovf)
  );

  // 100-unit clock period.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reference: plain WIDTH+1 bit arithmetic; overflow when both addends share
  // a sign that the result does not.
  function automatic void refModel(input logic [7:0] ra, input logic [7:0] rb,
                                   input logic rc, input logic rs,
                                   output logic [7:0] es, output logic ec,
                                   output logic eo);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] full;
    bb   = (SUB_EN && rs) ? ~rb : rb;
    cc   = (SUB_EN && rs) ? 1'b1 : rc;
    full = {1'b0, ra} + {1'b0, bb} + {8'd0, cc};
    es   = full[7:0];
    ec   = full[8];
    eo   = (ra[7] == bb[7]) && (full[7] != ra[7]);
  endfunction

  // Runs one operation from IDLE and reports what was observed: cycles from
  // accept to done, busy cycles, results, sum stability, and done afterwards.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                               input logic ic, input logic isb,
                               output int lat, output int busyCnt,
                               output logic [7:0] os, output logic oc,
                               output logic ov, output logic sumStable,
                               output logic doneAfter);
    logic [7:0] sumBefore;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; cIn = ic; sub = isb;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    cIn = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    sumBefore = sum;
    sumStable = 1'b1;
    lat = -1;
    busyCnt = busy ? 1 : 0;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busyCnt++;
      if (sum !== sumBefore) sumStable = 1'b0;
    end
    os = sum; oc = cOut; ov = ovf;
    @(negedge clk);
    doneAfter = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cIn = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_busy_done: busy=%b done=%b required 0 0", busy, done);
    end
    total++;
    if (sum !== 8'h00 || cOut !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_results: sum=%h cOut=%b ovf=%b required 00 0 0", sum, cOut, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    int lat, bc;
    logic [7:0] s;
    logic co, ov, st, da;
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, lat, bc, s, co, ov, st, da);
    total++;
    if (lat !== WIDTH) begin
      bad++;
      $display("[TB] FAIL basic_latency: got %0d required %0d", lat, WIDTH);
    end
    total++;
    if (bc !== WIDTH) begin
      bad++;
      $display("[TB] FAIL basic_busy_cycles: got %0d required %0d", bc, WIDTH);
    end
    total++;
    if (s !== 8'h10 || co !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_result: sum=%h cOut=%b ovf=%b required 10 0 0", s, co, ov);
    end
    total++;
    if (da !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done_width: done=%b one cycle later, required 0", da);
    end
    total++;
    if (st !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_sum_stable: sum changed during run, required stable");
    end
  endtask

  task automatic test_carry_wrap();
    int lat, bc;
    logic [7:0] s;
    logic co, ov, st, da;
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc, s, co, ov, st, da);
    total++;
    if (s !== 8'h00 || co !== 1'b1 || ov !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wrap_ff_01: sum=%h cOut=%b ovf=%b required 00 1 0", s, co, ov);
    end
    applyStimulus(8'h7F, 8'h00, 1'b1, 1'b0, lat, bc, s, co, ov, st, da);
    total++;
    if (s !== 8'h80 || co !== 1'b0 || ov !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_7f_cin: sum=%h cOut=%b ovf=%b required 80 0 1", s, co, ov);
    end
    total++;
    if (st !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wrap_sum_stable: sum changed before completion");
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    @(negedge clk);
    start = 1'b1; a = 8'h03; b = 8'h04; cIn = 1'b0; sub = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h11;
    lat = -1;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== WIDTH || sum !== 8'h07) begin
      bad++;
      $display("[TB] FAIL busy_ignore_start: latency=%0d sum=%h required %0d 07", lat, sum, WIDTH);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL back_to_back_accept: busy=%b done=%b required 1 0", busy, done);
    end
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 3 * WIDTH; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (sum !== 8'h07) begin
        total++;
        bad++;
        $display("[TB] FAIL back_to_back_hold: sum=%h during run, required 07", sum);
      end
    end
    total++;
    if (lat !== WIDTH || sum !== 8'hBB || cOut !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL back_to_back_result: latency=%0d sum=%h cOut=%b ovf=%b required %0d BB 0 0",
               lat, sum, cOut, ovf, WIDTH);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic sawDone;
    int lat, bc;
    logic [7:0] s;
    logic co, ov, st, da;
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h55; cIn = 1'b0; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cOut !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_op: busy=%b done=%b sum=%h cOut=%b ovf=%b required 0 0 00 0 0",
               busy, done, sum, cOut, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (3 * WIDTH) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    total++;
    if (sawDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_no_done: done seen after release, required none");
    end
    applyStimulus(8'h55, 8'h55, 1'b0, 1'b0, lat, bc, s, co, ov, st, da);
    total++;
    if (lat !== WIDTH || s !== 8'hAA || co !== 1'b0 || ov !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_fresh_op: latency=%0d sum=%h cOut=%b ovf=%b required %0d AA 0 1",
               lat, s, co, ov, WIDTH);
    end
  endtask

  task automatic test_sub();
    int lat, bc;
    logic [7:0] s;
    logic co, ov, st, da;
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, lat, bc, s, co, ov, st, da);
`ifdef SERIAL_SUB_EN
    total++;
    if (s !== 8'hFE || co !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_05_07: sum=%h cOut=%b ovf=%b required FE 0 0", s, co, ov);
    end
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, lat, bc, s, co, ov, st, da);
    total++;
    if (s !== 8'h7F || co !== 1'b1 || ov !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sub_80_01: sum=%h cOut=%b ovf=%b required 7F 1 1", s, co, ov);
    end
`else
    total++;
    if (s !== 8'h0C || co !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_ignored: sum=%h cOut=%b ovf=%b required 0C 0 0", s, co, ov);
    end
`endif
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] s, ra, rb, es;
    logic co, ov, st, da, rc, rs, ec, eo;
    for (int n = 0; n < 24; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, rs, lat, bc, s, co, ov, st, da);
      refModel(ra, rb, rc, rs, es, ec, eo);
      total++;
      if (lat !== WIDTH || s !== es || co !== ec || ov !== eo) begin
        bad++;
        $display("[TB] FAIL random_%0d a=%h b=%h cIn=%b sub=%b: latency=%0d sum=%h cOut=%b ovf=%b required %0d %h %b %b",
                 n, ra, rb, rc, rs, lat, s, co, ov, WIDTH, es, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_wrap();
    test_start_while_busy();
    test_reset_mid_op();
    test_sub();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
